// File: rtl/oam_responder.sv
`default_nettype none
// ============================================================================
//  Module   : oam_responder
//  Purpose  : Bridges the CPU bus and the OBJ engine to the 1 KB OAM.
//             The OBJ engine reads one word per cycle through a dedicated
//             port with one cycle of latency. CPU writes are posted into a
//             small FIFO and drained only while the OAM access window is
//             open. CPU reads are held until every earlier posted write has
//             landed.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock       in   1   system clock
//    reset_n     in   1   asynchronous active-low reset
//    gfx_addr    in   8   OAM word index from the OBJ engine
//    gfx_data    out  32  registered word at gfx_addr
//    cpu_req     in   1   CPU request, held until cpu_ready
//    cpu_we      in   1   1 = write, 0 = read
//    cpu_addr    in   10  byte address within OAM
//    cpu_size    in   2   0 = byte, 1 = halfword, 2/3 = word
//    cpu_wdata   in   32  write data, lane-replicated by the bus
//    cpu_ready   out  1   request accepted this cycle
//    cpu_rvalid  out  1   one-cycle read-data-valid pulse
//    cpu_rdata   out  32  read data word
//    dispcnt     in   16  DISPCNT register (bit 7 forced blank, bit 5
//                         H-blank interval free)
//    vblank      in   1   vertical blank active
//    hblank      in   1   horizontal blank active
//    fifo_level  out  3   posted-write FIFO occupancy
// ============================================================================
module oam_responder #(
  parameter int DEPTH = 4,
  parameter int WORDS = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  gfx_addr,
  output logic [31:0] gfx_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [9:0]  cpu_addr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic [15:0] dispcnt,
  input  logic        vblank,
  input  logic        hblank,
  output logic [2:0]  fifo_level
);

  localparam int c_AW = $clog2(WORDS);      // word index width
  localparam int c_PW = $clog2(DEPTH) + 1;  // pointer width incl. wrap bit

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAIN  = 2'd1,
    S_RDWAIT = 2'd2,
    S_RDRESP = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [31:0]     r_mem     [WORDS];
  logic [c_AW-1:0] r_fq_idx  [DEPTH];
  logic [3:0]      r_fq_be   [DEPTH];
  logic [31:0]     r_fq_data [DEPTH];

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t          r_state;
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [31:0]     r_gfx_data;
  logic [31:0]     r_rdata;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  state_t            w_state_nx;
  logic [c_PW-1:0]   w_count;
  logic              w_empty;
  logic              w_full;
  logic              w_open;
  logic              w_is_write;
  logic              w_is_byte;
  logic              w_rd_req;
  logic              w_push;
  logic              w_pop;
  logic              w_wr_ready;
  logic              w_rd_accept;
  logic [3:0]        w_push_be;
  logic [c_AW-1:0]   w_cpu_idx;
  logic [c_PW-2:0]   w_wr_slot;
  logic [c_PW-2:0]   w_rd_slot;
  logic [c_AW-1:0]   w_head_idx;
  logic [3:0]        w_head_be;
  logic [31:0]       w_head_data;
  logic              w_unused;

  // Only bits 7 and 5 of DISPCNT matter here; cpu_addr[0] never selects a
  // lane because halfword and word accesses are naturally aligned.
  assign w_unused = ^{dispcnt[15:8], dispcnt[6], dispcnt[4:0], cpu_addr[0]};

  // Occupancy from free-running pointers; the extra MSB distinguishes a
  // full FIFO from an empty one when the slot bits match.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == c_PW'(DEPTH));

  // Access window: forced blank, V-blank, or H-blank when the OBJ engine has
  // been told to leave the H-blank interval free.
  assign w_open = dispcnt[7] | vblank | (hblank & dispcnt[5]);

  assign w_is_write = cpu_req & cpu_we;
  assign w_rd_req   = cpu_req & ~cpu_we;
  assign w_is_byte  = (cpu_size == 2'd0);

  // Byte writes to OAM are dropped by the hardware, but the bus still needs
  // a handshake, so they are acknowledged regardless of FIFO state.
  assign w_wr_ready = w_is_write & (w_is_byte | ~w_full);
  assign w_push     = w_is_write & ~w_is_byte & ~w_full;

  always_comb begin
    w_push_be = 4'b1111;
    if (cpu_size == 2'd1) begin
      w_push_be = cpu_addr[1] ? 4'b1100 : 4'b0011;
    end
  end

  assign w_cpu_idx   = cpu_addr[c_AW+1:2];
  assign w_wr_slot   = r_wr_ptr[c_PW-2:0];
  assign w_rd_slot   = r_rd_ptr[c_PW-2:0];
  assign w_head_idx  = r_fq_idx[w_rd_slot];
  assign w_head_be   = r_fq_be[w_rd_slot];
  assign w_head_data = r_fq_data[w_rd_slot];

  // --------------------------------------------------------------------------
  // Control FSM: next state and port-B arbitration
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nx  = r_state;
    w_pop       = 1'b0;
    w_rd_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rd_req) begin
          // A read may only use port B once every older write has landed.
          if (w_open & w_empty) begin
            w_rd_accept = 1'b1;
            w_state_nx  = S_RDRESP;
          end else begin
            w_state_nx = S_RDWAIT;
          end
        end else if (w_open & ~w_empty) begin
          w_state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_pop = w_open & ~w_empty;
        // Leave when the window closes or this pop takes the last entry
        // without a simultaneous refill.
        if (~w_open | w_empty | ((w_count == c_PW'(1)) & ~w_push)) begin
          w_state_nx = S_IDLE;
        end
      end
      S_RDWAIT: begin
        if (~w_rd_req) begin
          w_state_nx = S_IDLE;
          w_pop      = w_open & ~w_empty;
        end else if (w_open & w_empty) begin
          w_rd_accept = 1'b1;
          w_state_nx  = S_RDRESP;
        end else begin
          w_pop = w_open & ~w_empty;
        end
      end
      S_RDRESP: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO pointers and entries
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
      end
    end
  end

  // Entry contents need no reset: the pointers alone define validity.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fq_idx[w_wr_slot]  <= w_cpu_idx;
      r_fq_be[w_wr_slot]   <= w_push_be;
      r_fq_data[w_wr_slot] <= cpu_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // OAM array, port B write side (drain). Not cleared by reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (w_pop) begin
      for (int b = 0; b < 4; b++) begin
        if (w_head_be[b]) begin
          r_mem[w_head_idx][8*b +: 8] <= w_head_data[8*b +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Port A (graphics) and port B read side. Both sample the array before any
  // same-edge drain write, giving read-first behaviour.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_gfx_data <= '0;
      r_rdata    <= '0;
    end else begin
      r_gfx_data <= r_mem[gfx_addr[c_AW-1:0]];
      if (w_rd_accept) begin
        r_rdata <= r_mem[w_cpu_idx];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign gfx_data   = r_gfx_data;
  assign cpu_rdata  = r_rdata;
  // Held low while reset is asserted so the bus never sees a handshake from
  // a block that is being cleared.
  assign cpu_ready  = reset_n & (w_wr_ready | w_rd_accept);
  assign cpu_rvalid = (r_state == S_RDRESP);
  assign fifo_level = 3'(w_count);

endmodule
`default_nettype wire
